// File: rtl/simd_pkg.sv
// Shared opcodes, FSM state encoding and default element width for the warp issue sequencer.
package simd_pkg;

  localparam int unsigned SIMD_W = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/simd_result_collector.sv
// Warp result buffer: cleared when an instruction is accepted, then filled one
// pass slice at a time with only the active lane results written.
module simd_result_collector
  import simd_pkg::*;
#(
  parameter int unsigned W     = SIMD_W,
  parameter int unsigned LANES = 4,
  parameter int unsigned WARP  = 16,
  parameter int unsigned PIW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_cap_vld,
  input  logic [PIW-1:0]       i_cap_idx,
  input  logic [LANES-1:0]     i_cap_mask,
  input  logic [LANES*W-1:0]   i_lane_out,
  output logic [WARP*W-1:0]    o_result
);

  logic [WARP*W-1:0] r_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else if (i_clear) begin
      r_buf <= '0;
    end else if (i_cap_vld) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (i_cap_mask[l]) begin
          r_buf[(32'(i_cap_idx) * LANES + 32'(l)) * W +: W] <= i_lane_out[l*W +: W];
        end
      end
    end
  end

  assign o_result = r_buf;

endmodule

// File: rtl/simd_warp_issue.sv
// Warp issue/collect sequencer driving LANES physical lanes over WARP/LANES passes.
// Build option SIMD_ISSUE_SKIP_EN: passes whose mask slice is all zero are not issued.
module simd_warp_issue
  import simd_pkg::*;
#(
  parameter int unsigned W     = SIMD_W,
  parameter int unsigned LANES = 4,
  parameter int unsigned WARP  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_opcode,
  input  logic [WARP-1:0]      in_mask,
  input  logic [WARP*W-1:0]    in_a,
  input  logic [WARP*W-1:0]    in_b,
  output logic [LANES-1:0]     lane_active,
  output logic [1:0]           lane_opcode,
  output logic [LANES*W-1:0]   lane_a,
  output logic [LANES*W-1:0]   lane_b,
  input  logic [LANES*W-1:0]   lane_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WARP*W-1:0]    out_result,
  output logic [WARP-1:0]      out_mask
);

  localparam int unsigned P   = WARP / LANES;
  localparam int unsigned PIW = $clog2(P + 1);

  state_t              r_state;
  logic [PIW-1:0]      r_pass;
  logic [1:0]          r_op;
  logic [WARP-1:0]     r_mask;
  logic [WARP*W-1:0]   r_a;
  logic [WARP*W-1:0]   r_b;
  logic                r_cap_vld;
  logic [PIW-1:0]      r_cap_idx;
  logic [LANES-1:0]    r_cap_mask;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [LANES-1:0]    r_lane_active;
  logic [1:0]          r_lane_op;
  logic [LANES*W-1:0]  r_lane_a;
  logic [LANES*W-1:0]  r_lane_b;

  state_t              w_state_nxt;
  logic [PIW-1:0]      w_pass_nxt;
  logic                w_accept;
  logic                w_issue;
  int unsigned         w_sel;
  logic [1:0]          w_src_op;
  logic [WARP-1:0]     w_src_mask;
  logic [WARP*W-1:0]   w_src_a;
  logic [WARP*W-1:0]   w_src_b;

`ifdef SIMD_ISSUE_SKIP_EN
  // Lowest pass index >= from whose mask slice is non-zero; P when none remain.
  function automatic logic [PIW-1:0] next_active(input logic [WARP-1:0] mask,
                                                  input int unsigned from);
    next_active = PIW'(P);
    for (int j = int'(P) - 1; j >= 0; j--) begin
      if (32'(j) >= from && mask[j*LANES +: LANES] != '0) next_active = PIW'(j);
    end
  endfunction
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = r_pass;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept = 1'b1;
`ifdef SIMD_ISSUE_SKIP_EN
          // An empty mask still spends one drain cycle: latency is issued passes + 1.
          w_pass_nxt  = next_active(in_mask, 0);
          w_state_nxt = (w_pass_nxt == PIW'(P)) ? ST_DRAIN : ST_RUN;
`else
          w_pass_nxt  = '0;
          w_state_nxt = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
`ifdef SIMD_ISSUE_SKIP_EN
        w_pass_nxt = next_active(r_mask, 32'(r_pass) + 1);
        if (w_pass_nxt == PIW'(P)) w_state_nxt = ST_DRAIN;
`else
        if (r_pass == PIW'(P - 1)) w_state_nxt = ST_DRAIN;
        else                       w_pass_nxt  = r_pass + 1'b1;
`endif
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_issue    = (w_state_nxt == ST_RUN);
  assign w_sel      = 32'(w_pass_nxt);
  assign w_src_op   = w_accept ? in_opcode : r_op;
  assign w_src_mask = w_accept ? in_mask   : r_mask;
  assign w_src_a    = w_accept ? in_a      : r_a;
  assign w_src_b    = w_accept ? in_b      : r_b;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: instruction latch, lane drive, and the one-cycle capture pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass        <= '0;
      r_op          <= OP_NOP;
      r_mask        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_cap_vld     <= 1'b0;
      r_cap_idx     <= '0;
      r_cap_mask    <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_lane_active <= '0;
      r_lane_op     <= OP_NOP;
      r_lane_a      <= '0;
      r_lane_b      <= '0;
    end else begin
      r_pass <= w_pass_nxt;
      if (w_accept) begin
        r_op   <= in_opcode;
        r_mask <= in_mask;
        r_a    <= in_a;
        r_b    <= in_b;
      end
      // Lanes register at the end of a RUN cycle; the buffer takes it one edge later.
      r_cap_vld   <= (r_state == ST_RUN);
      r_cap_idx   <= r_pass;
      r_cap_mask  <= r_lane_active;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      if (w_issue) begin
        r_lane_active <= w_src_mask[w_sel*LANES +: LANES];
        r_lane_op     <= w_src_op;
        r_lane_a      <= w_src_a[w_sel*LANES*W +: LANES*W];
        r_lane_b      <= w_src_b[w_sel*LANES*W +: LANES*W];
      end else begin
        r_lane_active <= '0;
        r_lane_op     <= OP_NOP;
        r_lane_a      <= '0;
        r_lane_b      <= '0;
      end
    end
  end

  simd_result_collector #(
    .W     (W),
    .LANES (LANES),
    .WARP  (WARP),
    .PIW   (PIW)
  ) u_collector (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_cap_vld  (r_cap_vld),
    .i_cap_idx  (r_cap_idx),
    .i_cap_mask (r_cap_mask),
    .i_lane_out (lane_out),
    .o_result   (out_result)
  );

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_mask    = r_mask;
  assign lane_active = r_lane_active;
  assign lane_opcode = r_lane_op;
  assign lane_a      = r_lane_a;
  assign lane_b      = r_lane_b;

endmodule

// File: tb/tb_simd_warp_issue.sv
// Bench for simd_warp_issue: lane array model, per-instruction behavioural reference,
// directed scenarios and randomized traffic. Honours SIMD_ISSUE_SKIP_EN when defined.
module tb_simd_warp_issue;

  localparam int unsigned W     = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned WARP  = 16;
  localparam int unsigned P     = WARP / LANES;
  localparam int unsigned VW    = WARP * W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [1:0]         in_opcode = 2'b11;
  logic [WARP-1:0]    in_mask = '0;
  logic [VW-1:0]      in_a = '0;
  logic [VW-1:0]      in_b = '0;
  logic [LANES-1:0]   lane_active;
  logic [1:0]         lane_opcode;
  logic [LANES*W-1:0] lane_a;
  logic [LANES*W-1:0] lane_b;
  logic [LANES*W-1:0] lane_out = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [VW-1:0]      out_result;
  logic [WARP-1:0]    out_mask;

  int checks = 0;
  int errors = 0;

  simd_warp_issue #(.W(W), .LANES(LANES), .WARP(WARP)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_mask     (in_mask),
    .in_a        (in_a),
    .in_b        (in_b),
    .lane_active (lane_active),
    .lane_opcode (lane_opcode),
    .lane_a      (lane_a),
    .lane_b      (lane_b),
    .lane_out    (lane_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_mask    (out_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return W'(a * b);
      2'b10:   return a & b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [VW-1:0] exp_vec(input logic [1:0] op, input logic [WARP-1:0] m,
                                            input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(WARP); i++)
      if (m[i]) v[i*W +: W] = alu(op, a[i*W +: W], b[i*W +: W]);
    return v;
  endfunction

  function automatic bit issued(input logic [WARP-1:0] m, input int p);
`ifdef SIMD_ISSUE_SKIP_EN
    return m[p*LANES +: LANES] != '0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int n_issued(input logic [WARP-1:0] m);
    int n;
    n = 0;
    for (int p = 0; p < int'(P); p++) if (issued(m, p)) n++;
    return n;
  endfunction

  // Index of the k-th issued pass.
  function automatic int pass_of(input logic [WARP-1:0] m, input int k);
    int c;
    c = 0;
    for (int p = 0; p < int'(P); p++) begin
      if (issued(m, p)) begin
        if (c == k) return p;
        c++;
      end
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane array: one-cycle registered results; disabled lanes return junk.
  always @(posedge clk)
    for (int l = 0; l < int'(LANES); l++)
      lane_out[l*W +: W] <= lane_active[l] ? alu(lane_opcode, lane_a[l*W +: W], lane_b[l*W +: W])
                                           : W'($urandom);

  // Reference: per accepted instruction, expected results, issued pass count and latency.
  bit              m_busy = 1'b0;
  int              m_cnt  = 0;
  int              m_n    = 0;
  int              m_lat  = 0;
  logic [1:0]      m_op   = 2'b11;
  logic [WARP-1:0] m_mask = '0;
  logic [VW-1:0]   m_a    = '0;
  logic [VW-1:0]   m_b    = '0;
  logic [VW-1:0]   m_res  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_op   <= in_opcode;
        m_mask <= in_mask;
        m_a    <= in_a;
        m_b    <= in_b;
        m_res  <= exp_vec(in_opcode, in_mask, in_a, in_b);
        m_n    <= n_issued(in_mask);
        m_lat  <= n_issued(in_mask) + 1;
      end
    end else if (m_cnt == m_lat) begin
      if (out_ready) m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", VW'(in_ready), VW'(!m_busy));
      chk("out_valid", VW'(out_valid), VW'(m_busy && m_cnt == m_lat));
      if (m_busy && m_cnt == m_lat) begin
        chk("out_result", out_result, m_res);
        chk("out_mask", VW'(out_mask), VW'(m_mask));
      end
      if (m_busy && m_cnt < m_n) begin
        chk("lane_active", VW'(lane_active), VW'(m_mask[pass_of(m_mask, m_cnt)*LANES +: LANES]));
        chk("lane_opcode", VW'(lane_opcode), VW'(m_op));
        chk("lane_a", VW'(lane_a), VW'(m_a[pass_of(m_mask, m_cnt)*LANES*W +: LANES*W]));
        chk("lane_b", VW'(lane_b), VW'(m_b[pass_of(m_mask, m_cnt)*LANES*W +: LANES*W]));
      end else begin
        chk("lane_idle", VW'(lane_active), '0);
      end
    end
  end

  logic [LANES-1:0] la_hist [0:15];

  // Called #1 after an edge; returns once the accept edge has passed.
  task automatic send(input logic [1:0] op, input logic [WARP-1:0] m,
                      input logic [VW-1:0] a, input logic [VW-1:0] b, input bit hold);
    int t;
    in_opcode = op; in_mask = m; in_a = a; in_b = b; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("accept_timeout", VW'(in_ready), VW'(1));
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, logging lane_active per cycle.
  task automatic wait_out(output int lat);
    lat = 0;
    la_hist[0] = lane_active;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat < 16) la_hist[lat] = lane_active;
    end
    if (!out_valid) chk("out_valid_timeout", VW'(out_valid), VW'(1));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < int'(WARP); i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  function automatic logic [WARP-1:0] rand_mask();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      2:       return WARP'($urandom);
      default: return WARP'($urandom % (1 << LANES)) << (LANES * $urandom_range(0, P - 1));
    endcase
  endfunction

  initial begin
    int lat;
    int vcount;
    logic [VW-1:0]   va, vb, ve;
    logic [VW-1:0]   snap_r;
    logic [WARP-1:0] snap_m;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", VW'(in_ready), VW'(1));
    chk("rst_out_valid", VW'(out_valid), '0);
    chk("rst_lane_active", VW'(lane_active), '0);
    chk("rst_lane_opcode", VW'(lane_opcode), VW'(2'b11));
    chk("rst_lane_ab", VW'({lane_a, lane_b}), '0);
    chk("rst_out_result", out_result, '0);
    chk("rst_out_mask", VW'(out_mask), '0);
    rst = 1'b0;

    // Reset in the middle of RUN abandons the instruction.
    send(2'b00, '1, rand_vec(), rand_vec(), 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    chk("no_valid_after_reset", VW'(vcount), '0);

    // add, a=i, b=100.
    for (int i = 0; i < int'(WARP); i++) begin
      va[i*W +: W] = W'(i);
      vb[i*W +: W] = W'(100);
      ve[i*W +: W] = W'(100 + i);
    end
    send(2'b00, '1, va, vb, 1'b0);
    wait_out(lat);
    chk("add_latency", VW'(lat), VW'(5));
    chk("add_elem5", VW'(out_result[5*W +: W]), VW'(105));
    chk("add_vector", out_result, ve);
    handshake();

    // mul overflow truncates to zero.
    for (int i = 0; i < int'(WARP); i++) begin
      va[i*W +: W] = 32'h0001_0000;
      vb[i*W +: W] = 32'h0001_0000;
    end
    send(2'b01, '1, va, vb, 1'b0);
    wait_out(lat);
    chk("mul_result", out_result, '0);
    chk("mul_mask", VW'(out_mask), VW'(16'hFFFF));
    handshake();

    // and on a single active pass.
    ve = '0;
    for (int i = 0; i < int'(WARP); i++) begin
      va[i*W +: W] = 32'h0F0F_1234;
      vb[i*W +: W] = 32'hFF00_FF00;
      if (i >= 4 && i <= 7) ve[i*W +: W] = 32'h0F00_1200;
    end
    send(2'b10, 16'h00F0, va, vb, 1'b0);
    wait_out(lat);
`ifdef SIMD_ISSUE_SKIP_EN
    chk("and_latency", VW'(lat), VW'(2));
    chk("and_pass_seq", VW'({la_hist[0], la_hist[1]}), VW'(8'hF0));
`else
    chk("and_latency", VW'(lat), VW'(5));
    chk("and_pass_seq", VW'({la_hist[0], la_hist[1], la_hist[2], la_hist[3]}), VW'(16'h0F00));
`endif
    chk("and_result", out_result, ve);
    handshake();

    // Back-pressure in DONE, then back-to-back accept.
    send(2'b00, '1, rand_vec(), rand_vec(), 1'b0);
    wait_out(lat);
    snap_r = out_result;
    snap_m = out_mask;
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_result", out_result, snap_r);
      chk("hold_mask", VW'(out_mask), VW'(snap_m));
      chk("hold_in_ready", VW'(in_ready), '0);
    end
    in_opcode = 2'b00; in_mask = '1; in_a = rand_vec(); in_b = rand_vec(); in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_valid_drop", VW'(out_valid), '0);
    chk("b2b_bubble_ready", VW'(in_ready), VW'(1));
    @(posedge clk); #1;
    chk("b2b_accepted", VW'(in_ready), '0);
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b_latency", VW'(lat), VW'(5));
    handshake();

    // nop yields zeros for active elements.
    send(2'b11, '1, rand_vec(), rand_vec(), 1'b0);
    wait_out(lat);
    chk("nop_result", out_result, '0);
    handshake();

    // Randomized traffic with random back-pressure and occasional reset.
    repeat (3000) begin
      @(posedge clk); #1;
      rst       = ($urandom % 400) == 0;
      in_valid  = ($urandom % 3) != 0;
      in_opcode = 2'($urandom);
      in_mask   = rand_mask();
      in_a      = rand_vec();
      in_b      = rand_vec();
      out_ready = ($urandom % 4) != 0;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
